// File: rtl/jtdsp16_ram.sv
// Internal data RAM of the DSP16 core.
// The core owns every clk edge with cen=1. A handshaked host/debug port uses
// the edges with cen=0, so the two sides never touch the array on the same edge
// and a single shared address/write port is enough.
module jtdsp16_ram #(
  parameter int AW = 11
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic [10:0]   ram_addr,
  input  logic          ram_we,
  input  logic [15:0]   ram_din,
  output logic [15:0]   ram_dout,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [15:0]   host_din,
  output logic [15:0]   host_dout,
  output logic          host_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} st_t;

  logic [15:0]   mem [2**AW];
  st_t           state_q, state_d;
  logic [15:0]   ram_dout_q, host_dout_q;
  logic          host_go;
  logic [AW-1:0] acc_addr;
  logic          mem_we;
  logic [15:0]   mem_wd;
  // Upper core address bits alias; they are intentionally not decoded.
  logic [10:0]   ram_addr_unused;

  assign ram_addr_unused = ram_addr;

  // Shared array port: core on cen=1 edges, host on cen=0 edges.
  always_comb begin
    acc_addr = host_addr;
    mem_we   = host_go & host_we;
    mem_wd   = host_din;
    if (cen) begin
      acc_addr = ram_addr[AW-1:0];
      mem_we   = ram_we;
      mem_wd   = ram_din;
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr] <= mem_wd;
  end

  // Read registers: core read is write-first, host read only on host read access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_dout_q  <= '0;
      host_dout_q <= '0;
    end else begin
      if (cen)                 ram_dout_q  <= ram_we ? ram_din : mem[acc_addr];
      if (host_go && !host_we) host_dout_q <= mem[acc_addr];
    end
  end

  // Host FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Host FSM next state: access once, ack once, then wait for the request to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (host_req && !cen) state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!host_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host FSM outputs: access strobe and ack decoded from the registered state.
  always_comb begin
    host_go  = (state_q == S_IDLE) && host_req && !cen;
    host_ack = (state_q == S_ACK);
  end

  assign ram_dout  = ram_dout_q;
  assign host_dout = host_dout_q;

endmodule
